// File: rtl/pulse_train_gen.sv
// Programmable pulse-train generator: N pulses of programmable high/low width after a start strobe.
// Latency: first high cycle directly after the start edge; abort idles after one edge. No backpressure.
// Optional continuous mode (num_pulse==0 repeats forever) under PULSE_TRAIN_GEN_CONTINUOUS_EN.
module pulse_train_gen #(
    parameter int CNT_W = 16,
    parameter int NUM_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic [CNT_W-1:0] i_high_len,
    input  logic [CNT_W-1:0] i_low_len,
    input  logic [NUM_W-1:0] i_num_pulse,
    output logic             o_wave,
    output logic             o_fall,
    output logic             o_busy,
    output logic             o_done
);

    typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [NUM_W-1:0] NUM_ONE = {{(NUM_W-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [CNT_W-1:0] phase_q, phase_d;
    logic [CNT_W-1:0] high_len_q, high_len_d;
    logic [CNT_W-1:0] low_len_q, low_len_d;
    logic [NUM_W-1:0] pulse_q, pulse_d;
    logic             wave_q, wave_d;
    logic             fall_q, fall_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             cont_mode;

    // A zero width still occupies one cycle so every pulse is visible.
    function automatic logic [CNT_W-1:0] clamp1(input logic [CNT_W-1:0] v);
        return (v == '0) ? CNT_ONE : v;
    endfunction

`ifdef PULSE_TRAIN_GEN_CONTINUOUS_EN
    logic cont_q, cont_d;
    assign cont_mode = cont_q;
`else
    assign cont_mode = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        high_len_d = high_len_q;
        low_len_d  = low_len_q;
        pulse_d    = pulse_q;
        fall_d     = 1'b0;
        done_d     = 1'b0;
`ifdef PULSE_TRAIN_GEN_CONTINUOUS_EN
        cont_d     = cont_q;
`endif
        case (state_q)
            IDLE: begin
                if (i_start && !i_abort) begin
                    high_len_d = clamp1(i_high_len);
                    low_len_d  = clamp1(i_low_len);
                    phase_d    = clamp1(i_high_len);
                    pulse_d    = i_num_pulse;
`ifdef PULSE_TRAIN_GEN_CONTINUOUS_EN
                    cont_d     = (i_num_pulse == '0);
                    state_d    = HIGH;
`else
                    if (i_num_pulse == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = HIGH;
                    end
`endif
                end
            end
            HIGH: begin
                if (phase_q <= CNT_ONE) begin
                    state_d = LOW;
                    phase_d = low_len_q;
                    fall_d  = 1'b1;
                end else begin
                    phase_d = phase_q - CNT_ONE;
                end
            end
            LOW: begin
                if (phase_q > CNT_ONE) begin
                    phase_d = phase_q - CNT_ONE;
                end else if (cont_mode || pulse_q > NUM_ONE) begin
                    state_d = HIGH;
                    phase_d = high_len_q;
                    pulse_d = cont_mode ? pulse_q : pulse_q - NUM_ONE;
                end else begin
                    state_d = IDLE;
                    phase_d = '0;
                    pulse_d = '0;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Abort wins over everything, including a same-cycle start.
        if (i_abort) begin
            state_d = IDLE;
            phase_d = '0;
            pulse_d = '0;
            fall_d  = 1'b0;
            done_d  = 1'b0;
`ifdef PULSE_TRAIN_GEN_CONTINUOUS_EN
            cont_d  = 1'b0;
`endif
        end

        wave_d = (state_d == HIGH);
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= IDLE;
            phase_q    <= '0;
            high_len_q <= '0;
            low_len_q  <= '0;
            pulse_q    <= '0;
            wave_q     <= 1'b0;
            fall_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef PULSE_TRAIN_GEN_CONTINUOUS_EN
            cont_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            high_len_q <= high_len_d;
            low_len_q  <= low_len_d;
            pulse_q    <= pulse_d;
            wave_q     <= wave_d;
            fall_q     <= fall_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
`ifdef PULSE_TRAIN_GEN_CONTINUOUS_EN
            cont_q     <= cont_d;
`endif
        end
    end

    assign o_wave = wave_q;
    assign o_fall = fall_q;
    assign o_busy = busy_q;
    assign o_done = done_q;

endmodule

// File: tb/tb_pulse_train_gen.sv
// Bench for pulse_train_gen: a timing model (offset-from-start arithmetic) checked every cycle,
// plus captured waveforms compared with hand-computed bit patterns.
module tb_pulse_train_gen;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_start;
    logic        i_abort;
    logic [15:0] i_high_len;
    logic [15:0] i_low_len;
    logic [7:0]  i_num_pulse;
    logic        o_wave, o_fall, o_busy, o_done;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    pulse_train_gen #(.CNT_W(16), .NUM_W(8)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_abort(i_abort),
        .i_high_len(i_high_len), .i_low_len(i_low_len), .i_num_pulse(i_num_pulse),
        .o_wave(o_wave), .o_fall(o_fall), .o_busy(o_busy), .o_done(o_done)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: t is the 1-based offset of the current cycle from the accepted start edge.
    bit m_active = 1'b0, m_cont = 1'b0;
    int m_t = 0, m_h = 1, m_l = 1, m_n = 0;
    bit e_wave = 1'b0, e_fall = 1'b0, e_busy = 1'b0, e_done = 1'b0;

    always @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            m_active = 1'b0; m_cont = 1'b0;
            e_wave = 1'b0; e_fall = 1'b0; e_busy = 1'b0; e_done = 1'b0;
        end else begin
            e_done = 1'b0;
            if (i_abort) begin
                m_active = 1'b0;
            end else if (m_active) begin
                m_t++;
            end else if (i_start) begin
                m_h = (i_high_len == 0) ? 1 : int'(i_high_len);
                m_l = (i_low_len == 0) ? 1 : int'(i_low_len);
                m_n = int'(i_num_pulse);
                m_t = 1;
                m_cont = 1'b0;
                if (m_n != 0) m_active = 1'b1;
`ifdef PULSE_TRAIN_GEN_CONTINUOUS_EN
                else begin m_active = 1'b1; m_cont = 1'b1; end
`else
                else e_done = 1'b1;
`endif
            end
            if (m_active && !m_cont && m_t > m_n * (m_h + m_l)) begin
                m_active = 1'b0;
                e_done = 1'b1;
            end
            e_busy = m_active;
            e_wave = m_active && (((m_t - 1) % (m_h + m_l)) < m_h);
            e_fall = m_active && (((m_t - 1) % (m_h + m_l)) == m_h);
        end
    end

    always begin
        @(posedge i_clk);
        #1;
        if (chk_en && !i_rst) begin
            chk("cyc_wave", {31'b0, o_wave}, {31'b0, e_wave});
            chk("cyc_fall", {31'b0, o_fall}, {31'b0, e_fall});
            chk("cyc_busy", {31'b0, o_busy}, {31'b0, e_busy});
            chk("cyc_done", {31'b0, o_done}, {31'b0, e_done});
        end
    end

    // Bit j of each vector is the value in cycle k+j (start sampled at edge k).
    task automatic run_capture(input int h, input int l, input int n, input int ncyc,
                               input int inj_cyc, input int inj_h, input int inj_n,
                               input int abort_cyc,
                               output logic [31:0] w, output logic [31:0] f,
                               output logic [31:0] b, output logic [31:0] d,
                               output logic [31:0] mw, output logic [31:0] mf);
        w = '0; f = '0; b = '0; d = '0; mw = '0; mf = '0;
        @(negedge i_clk);
        i_high_len = 16'(h); i_low_len = 16'(l); i_num_pulse = 8'(n); i_start = 1'b1;
        for (int j = 1; j <= ncyc; j++) begin
            @(posedge i_clk);
            #1;
            i_start = 1'b0;
            i_abort = 1'b0;
            w[j] = o_wave; f[j] = o_fall; b[j] = o_busy; d[j] = o_done;
            mw[j] = e_wave; mf[j] = e_fall;
            if (j == inj_cyc) begin
                i_high_len = 16'(inj_h); i_num_pulse = 8'(inj_n); i_start = 1'b1;
            end
            if (j == abort_cyc) i_abort = 1'b1;
        end
    endtask

    logic [31:0] cw, cf, cb, cd, mw, mf;
    int nfall, ndone;

    initial begin
        i_rst = 1'b1; i_start = 1'b0; i_abort = 1'b0;
        i_high_len = '0; i_low_len = '0; i_num_pulse = '0;
        #1;
        chk("rst_wave", {31'b0, o_wave}, 32'd0);
        chk("rst_busy", {31'b0, o_busy}, 32'd0);
        chk("rst_done", {31'b0, o_done}, 32'd0);
        chk("rst_fall", {31'b0, o_fall}, 32'd0);
        repeat (3) @(negedge i_clk);
        i_rst = 1'b0;
        chk_en = 1'b1;
        repeat (2) @(negedge i_clk);

        run_capture(3, 2, 2, 12, 0, 0, 0, 0, cw, cf, cb, cd, mw, mf);
        chk("basic_wave", cw, 32'h1CE);
        chk("basic_fall", cf, 32'h210);
        chk("basic_busy", cb, 32'h7FE);
        chk("basic_done", cd, 32'h800);
        chk("model_basic_wave", mw, 32'h1CE);
        chk("model_basic_fall", mf, 32'h210);

        run_capture(0, 0, 3, 8, 0, 0, 0, 0, cw, cf, cb, cd, mw, mf);
        chk("zero_wave", cw, 32'h2A);
        chk("zero_fall", cf, 32'h54);
        chk("zero_busy", cb, 32'h7E);
        chk("zero_done", cd, 32'h80);
        chk("model_zero_wave", mw, 32'h2A);

        run_capture(3, 2, 2, 12, 2, 9, 2, 0, cw, cf, cb, cd, mw, mf);
        chk("busy_start_wave", cw, 32'h1CE);
        chk("busy_start_done", cd, 32'h800);

        run_capture(3, 2, 2, 12, 0, 0, 0, 2, cw, cf, cb, cd, mw, mf);
        chk("abort_wave", cw, 32'h6);
        chk("abort_busy", cb, 32'h6);
        chk("abort_fall", cf, 32'h0);
        chk("abort_done", cd, 32'h0);
        chk("model_abort_wave", mw, 32'h6);

        @(negedge i_clk);
        i_high_len = 16'd3; i_low_len = 16'd2; i_num_pulse = 8'd2;
        i_start = 1'b1; i_abort = 1'b1;
        @(posedge i_clk);
        #1;
        i_start = 1'b0; i_abort = 1'b0;
        chk("start_abort_busy", {31'b0, o_busy}, 32'd0);
        chk("start_abort_wave", {31'b0, o_wave}, 32'd0);
        repeat (3) @(negedge i_clk);
        chk("start_abort_idle", {31'b0, o_busy}, 32'd0);

`ifdef PULSE_TRAIN_GEN_CONTINUOUS_EN
        nfall = 0; ndone = 0;
        @(negedge i_clk);
        i_high_len = 16'd1; i_low_len = 16'd1; i_num_pulse = 8'd0; i_start = 1'b1;
        for (int j = 1; j <= 50; j++) begin
            @(posedge i_clk);
            #1;
            i_start = 1'b0;
            nfall += int'(o_fall);
            ndone += int'(o_done);
        end
        i_abort = 1'b1;
        @(posedge i_clk);
        #1;
        i_abort = 1'b0;
        chk("cont_falls", nfall, 32'd25);
        chk("cont_done", ndone, 32'd0);
        chk("cont_abort_busy", {31'b0, o_busy}, 32'd0);
`else
        run_capture(2, 1, 0, 6, 1, 2, 1, 0, cw, cf, cb, cd, mw, mf);
        chk("n0_b2b_wave", cw, 32'hC);
        chk("n0_b2b_fall", cf, 32'h10);
        chk("n0_b2b_busy", cb, 32'h1C);
        chk("n0_b2b_done", cd, 32'h22);
`endif

        @(negedge i_clk);
        i_high_len = 16'd3; i_low_len = 16'd2; i_num_pulse = 8'd4; i_start = 1'b1;
        @(posedge i_clk);
        #1;
        i_start = 1'b0;
        repeat (4) @(posedge i_clk);
        #3;
        chk("pre_rst_busy", {31'b0, o_busy}, 32'd1);
        i_rst = 1'b1;
        #1;
        chk("mid_rst_wave", {31'b0, o_wave}, 32'd0);
        chk("mid_rst_busy", {31'b0, o_busy}, 32'd0);
        chk("mid_rst_fall", {31'b0, o_fall}, 32'd0);
        chk("mid_rst_done", {31'b0, o_done}, 32'd0);
        @(negedge i_clk);
        i_rst = 1'b0;
        for (int j = 0; j < 6; j++) begin
            @(negedge i_clk);
            chk("post_rst_idle", {31'b0, o_busy | o_wave}, 32'd0);
        end

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
